// File: rtl/sample_capture_writer_if.sv
// Bus bundle for the threshold-triggered sample recorder.
// The master drives the capture controls and read address; the slave is the recorder.
interface sample_capture_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  stop;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  armed;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   sample_count;

  modport master (
    output start, stop, in_valid, in_data, rd_addr,
    input  rd_data, armed, busy, done, overflow, sample_count
  );

  modport slave (
    input  start, stop, in_valid, in_data, rd_addr,
    output rd_data, armed, busy, done, overflow, sample_count
  );
endinterface

// File: rtl/sample_capture_writer.sv
// Threshold-triggered sample recorder: arms on start, begins storing at the first
// sample whose magnitude reaches THRESHOLD, and stops when full or on stop.
module sample_capture_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int THRESHOLD  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  sample_capture_writer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);
  localparam logic [DATA_WIDTH:0] THRESH_C = (DATA_WIDTH+1)'(THRESHOLD);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   count_inc_s;
  logic                  overflow_q, overflow_d;
  logic                  full_q, full_d;
  logic                  armed_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH:0]   mag_s;
  logic                  trig_s;

  // One extra bit keeps -128 as +128 instead of wrapping back to negative.
  always_comb begin
    if (bus.in_data[DATA_WIDTH-1]) begin
      mag_s = (DATA_WIDTH+1)'(0) - {1'b1, bus.in_data};
    end else begin
      mag_s = {1'b0, bus.in_data};
    end
  end

  assign trig_s      = (mag_s >= THRESH_C);
  assign count_inc_s = count_q + ONE_C;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    full_d     = full_q;
    wr_en_s    = 1'b0;
    wr_addr_s  = count_q[ADDR_WIDTH-1:0];
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_ARMED;
          count_d    = '0;
          overflow_d = 1'b0;
          full_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (bus.stop) begin
          state_d = S_DONE;
        end else if (bus.in_valid && trig_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = '0;
          count_d   = ONE_C;
          state_d   = S_CAPTURE;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_CAPTURE: begin
        // A stop coinciding with a valid sample still stores that sample.
        if (bus.in_valid) begin
          wr_en_s = 1'b1;
          count_d = count_inc_s;
          if (count_inc_s == DEPTH_C) begin
            state_d = S_DONE;
            full_d  = 1'b1;
          end else begin
            full_d = full_q;
          end
        end else begin
          count_d = count_q;
        end
        if (bus.stop) begin
          state_d = S_DONE;
        end else begin
          wr_addr_s = count_q[ADDR_WIDTH-1:0];
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_d    = S_ARMED;
          count_d    = '0;
          overflow_d = 1'b0;
          full_d     = 1'b0;
        end else if (bus.in_valid && full_q) begin
          overflow_d = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      armed_q    <= (state_d == S_ARMED);
      busy_q     <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
      done_q     <= (state_d == S_DONE);
      rd_data_q  <= mem_q[bus.rd_addr];
    end
  end

  // Buffer is deliberately not reset so a partial capture survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en_s && rst_n) begin
      mem_q[wr_addr_s] <= bus.in_data;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.armed        = armed_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overflow     = overflow_q;
  assign bus.sample_count = count_q;

endmodule

// File: tb/tb_sample_capture_writer.sv
// Directed bench for sample_capture_writer: a cycle-level behavioural model is
// compared against the DUT every cycle, plus hand-computed literal checkpoints.
module tb_sample_capture_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_capture_writer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  sample_capture_writer #(
    .DATA_WIDTH(8), .DEPTH(256), .ADDR_WIDTH(8), .THRESHOLD(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: recorder phase flags, captured count, and a shadow of the buffer.
  bit         m_wait, m_rec, m_fin, m_full, m_ovf;
  int         m_cnt;
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_rd;
  bit         m_rd_known;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int magnitude(input logic [7:0] d);
    int s;
    s = $signed(d);
    return (s < 0) ? -s : s;
  endfunction

  task automatic model_write(input int addr, input logic [7:0] d);
    m_mem[addr]   = d;
    m_known[addr] = 1'b1;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_wait = 0; m_rec = 0; m_fin = 0; m_full = 0; m_ovf = 0;
      m_cnt = 0; m_rd = 8'h00; m_rd_known = 1'b1;
    end else begin
      m_rd       = m_mem[bus.rd_addr];
      m_rd_known = m_known[bus.rd_addr];
      if (bus.start && !m_wait && !m_rec) begin
        m_wait = 1; m_fin = 0; m_cnt = 0; m_ovf = 0; m_full = 0;
      end else if (m_wait) begin
        if (bus.stop) begin
          m_wait = 0; m_fin = 1;
        end else if (bus.in_valid && magnitude(bus.in_data) >= 16) begin
          model_write(0, bus.in_data);
          m_cnt = 1; m_wait = 0; m_rec = 1;
        end
      end else if (m_rec) begin
        if (bus.in_valid) begin
          model_write(m_cnt % 256, bus.in_data);
          m_cnt++;
          if (m_cnt == 256) begin
            m_rec = 0; m_fin = 1; m_full = 1;
          end
        end
        if (bus.stop) begin
          m_rec = 0; m_fin = 1;
        end
      end else if (m_fin && bus.in_valid && m_full) begin
        m_ovf = 1;
      end
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("armed",        32'(bus.armed),        32'(m_wait));
      check("busy",         32'(bus.busy),         32'(m_wait | m_rec));
      check("done",         32'(bus.done),         32'(m_fin));
      check("overflow",     32'(bus.overflow),     32'(m_ovf));
      check("sample_count", 32'(bus.sample_count), 32'(m_cnt));
      if (m_rd_known) check("rd_data", 32'(bus.rd_data), 32'(m_rd));
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit st, input bit sp,
                      input logic [7:0] ra);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.start    = st;
    bus.stop     = sp;
    bus.rd_addr  = ra;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.start = 1'b0;
    bus.stop = 1'b0; bus.rd_addr = 8'h00;

    // Reset held two cycles with a loud sample present.
    rst_n = 1'b0;
    step(1'b1, 8'd100, 1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    step(1'b1, 8'd100, 1'b0, 1'b0, 8'h00);
    check("lit_reset_count", 32'(bus.sample_count), 32'd0);
    check("lit_reset_done",  32'(bus.done),         32'd0);
    check("lit_reset_rd",    32'(bus.rd_data),      32'd0);
    rst_n = 1'b1;
    step(1'b1, 8'd100, 1'b0, 1'b0, 8'h00);
    check("lit_idle_busy", 32'(bus.busy), 32'd0);

    // Trigger gating: 5, -15, 15 discarded, -16 triggers.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check("lit_armed", 32'(bus.armed), 32'd1);
    step(1'b1, 8'd5,  1'b0, 1'b0, 8'h00);
    step(1'b1, 8'hF1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'd15, 1'b0, 1'b0, 8'h00);
    check("lit_below_thr_count", 32'(bus.sample_count), 32'd0);
    step(1'b1, 8'hF0, 1'b0, 1'b0, 8'h00);
    check("lit_trig_count", 32'(bus.sample_count), 32'd1);
    check("lit_trig_armed", 32'(bus.armed),        32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("lit_trig_rd0", 32'(bus.rd_data), 32'h0000_00F0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);

    // Full capture from -128 plus 255-sample ramp, with an ignored start.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b1, 8'h80, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i < 256; i++) step(1'b1, 8'(i), (i == 10), 1'b0, 8'h00);
    check("lit_full_count", 32'(bus.sample_count), 32'd256);
    check("lit_full_done",  32'(bus.done),         32'd1);
    check("lit_full_busy",  32'(bus.busy),         32'd0);
    step(1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
    check("lit_overflow", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'(i));
      if (i == 0)   check("lit_rd_addr0",   32'(bus.rd_data), 32'h0000_0080);
      if (i == 255) check("lit_rd_addr255", 32'(bus.rd_data), 32'h0000_00FF);
    end

    // start+stop together in DONE: start wins and overflow clears.
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
    check("lit_restart_armed", 32'(bus.armed),    32'd1);
    check("lit_restart_ovf",   32'(bus.overflow), 32'd0);

    // Early stop on the third post-trigger sample.
    step(1'b1, 8'd40, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'd1,  1'b0, 1'b0, 8'h00);
    step(1'b1, 8'd2,  1'b0, 1'b0, 8'h00);
    step(1'b1, 8'd3,  1'b0, 1'b1, 8'h00);
    check("lit_stop_count", 32'(bus.sample_count), 32'd4);
    check("lit_stop_done",  32'(bus.done),         32'd1);
    step(1'b1, 8'd9, 1'b0, 1'b0, 8'h03);
    check("lit_stop_ovf", 32'(bus.overflow), 32'd0);
    check("lit_stop_rd3", 32'(bus.rd_data),  32'd3);

    // Stop while armed.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    check("lit_armstop_done",  32'(bus.done),         32'd1);
    check("lit_armstop_count", 32'(bus.sample_count), 32'd0);

    // Reset mid-capture keeps the buffer.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) step(1'b1, 8'(20 + 3 * k), 1'b0, 1'b0, 8'h00);
    check("lit_mid_count", 32'(bus.sample_count), 32'd10);
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check("lit_mid_rst_count", 32'(bus.sample_count), 32'd0);
    check("lit_mid_rst_busy",  32'(bus.busy),         32'd0);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h05);
    check("lit_mid_rd5", 32'(bus.rd_data), 32'd35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
